// File: rtl/wb_bram_initiator.sv
// Wishbone classic initiator for the user-area BRAM window: one command runs a burst of
// single-word cycles with incrementing address, streamed write/read data and a per-word ack timeout.
module wb_bram_initiator #(
  parameter int TIMEOUT = 64,
  parameter int LEN_W   = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rstn_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [31:0]      cmd_adr_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic [31:0]      wdata_i,
  input  logic             wdata_valid_i,
  output logic             wdata_ready_o,
  output logic [31:0]      rdata_o,
  output logic             rdata_valid_o,
  input  logic             rdata_ready_i,
  output logic             done_o,
  output logic             err_o,
  output logic             busy_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic             wbm_ack_i,
  input  logic [31:0]      wbm_dat_i
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_WDATA, S_REQ, S_RDATA, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             we_q, we_d;
  logic [31:0]      adr_q, adr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cyc_q, cyc_d;
  logic [31:0]      dat_q, dat_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [LEN_W-1:0] rem_dec;

  assign rem_dec = rem_q - LEN_W'(1);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    adr_d   = adr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    dat_d   = dat_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          we_d  = cmd_we_i;
          adr_d = cmd_adr_i & 32'hFFFF_FFFC;
          rem_d = cmd_len_i;
          err_d = 1'b0;
          if (cmd_len_i == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (cmd_we_i) begin
            state_d = S_WDATA;
          end else begin
            state_d = S_REQ;
            cyc_d   = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      S_WDATA: begin
        if (wdata_valid_i) begin
          dat_d   = wdata_i;
          state_d = S_REQ;
          cyc_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      S_REQ: begin
        // An ack arriving on the last allowed cycle still completes the word.
        if (wbm_ack_i) begin
          cyc_d = 1'b0;
          if (!we_q) begin
            rdata_d = wbm_dat_i;
            state_d = S_RDATA;
          end else begin
            rem_d = rem_dec;
            adr_d = adr_q + 32'd4;
            if (rem_dec != '0) begin
              state_d = S_WDATA;
            end else begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          cyc_d   = 1'b0;
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RDATA: begin
        if (rdata_ready_i) begin
          rem_d = rem_dec;
          adr_d = adr_q + 32'd4;
          if (rem_dec != '0) begin
            state_d = S_REQ;
            cyc_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      adr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      dat_q   <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready_o   = (state_q == S_IDLE);
  assign wdata_ready_o = (state_q == S_WDATA);
  assign rdata_valid_o = (state_q == S_RDATA);
  assign busy_o        = (state_q != S_IDLE);
  assign rdata_o       = rdata_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign wbm_cyc_o     = cyc_q;
  assign wbm_stb_o     = cyc_q;
  assign wbm_we_o      = we_q;
  assign wbm_sel_o     = {4{cyc_q}};
  assign wbm_adr_o     = adr_q;
  assign wbm_dat_o     = dat_q;

endmodule

// File: tb/tb_wb_bram_initiator.sv
// Scoreboard bench for wb_bram_initiator: a BRAM slave model with programmable ack delay,
// a reference memory producing expected bus beats, read words and error flags.
module tb_wb_bram_initiator;
  localparam int TO    = 64;
  localparam int LEN_W = 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic             cmd_valid, cmd_ready, cmd_we;
  logic [31:0]      cmd_adr;
  logic [LEN_W-1:0] cmd_len;
  logic [31:0]      wdata, rdata;
  logic             wdata_valid, wdata_ready, rdata_valid, rdata_ready;
  logic             done, err, busy;
  logic             cyc, stb, we_o, ack;
  logic [3:0]       sel;
  logic [31:0]      adr_o, dat_o, dat_i;

  wb_bram_initiator #(.TIMEOUT(TO), .LEN_W(LEN_W)) dut (
    .wb_clk_i(clk), .wb_rstn_i(rstn),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_len_i(cmd_len),
    .wdata_i(wdata), .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready),
    .rdata_o(rdata), .rdata_valid_o(rdata_valid), .rdata_ready_i(rdata_ready),
    .done_o(done), .err_o(err), .busy_o(busy),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we_o), .wbm_sel_o(sel),
    .wbm_adr_o(adr_o), .wbm_dat_o(dat_o), .wbm_ack_i(ack), .wbm_dat_i(dat_i)
  );

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endfunction

  // slave: registered ack after slv_delay wait cycles
  logic [31:0] slv_mem [logic [31:0]];
  int  slv_delay = 0;
  int  slv_cnt   = 0;
  bit  slv_noack = 1'b0;

  always @(posedge clk) begin
    ack <= 1'b0;
    if (cyc && stb && !ack && !slv_noack) begin
      if (slv_cnt >= slv_delay) begin
        ack <= 1'b1;
        slv_cnt = 0;
        if (we_o) begin
          slv_mem[adr_o] = dat_o;
          dat_i <= $urandom;
        end else begin
          dat_i <= slv_mem.exists(adr_o) ? slv_mem[adr_o] : 32'h0;
        end
      end else begin
        slv_cnt++;
      end
    end else if (!stb) begin
      slv_cnt = 0;
    end
  end

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
  } beat_t;

  logic [31:0] ref_mem [logic [31:0]];
  beat_t       exp_bus[$];
  logic [31:0] exp_rd[$];
  bit          exp_err[$];
  logic [31:0] wq[$];

  int   rd_mode = 0;
  int   hold = 0;
  bit   chk_run = 1'b0;
  int   run = 0;
  int   done_cnt = 0;
  bit   wd_hs = 1'b0, stb_prev = 1'b0, done_prev = 1'b0;
  bit   pv_valid = 1'b0, pv_ready = 1'b0;
  logic [31:0] pv_rdata = '0;

  always @(negedge clk) begin
    beat_t b;
    logic [31:0] r;
    bit e;
    if (wd_hs && wq.size() > 0) void'(wq.pop_front());
    if (wq.size() > 0 && $urandom_range(3) != 0) begin
      wdata_valid = 1'b1;
      wdata = wq[0];
    end else begin
      wdata_valid = 1'b0;
    end
    wd_hs = wdata_valid && wdata_ready;

    case (rd_mode)
      0: rdata_ready = 1'b1;
      1: rdata_ready = 1'($urandom_range(1));
      default: begin
        if (rdata_valid && hold < 5) begin
          rdata_ready = 1'b0;
          hold++;
        end else begin
          rdata_ready = 1'b1;
          hold = 0;
        end
      end
    endcase

    if (rdata_valid && pv_valid && !pv_ready) chk("rdata_stable", rdata, pv_rdata);
    if (rdata_valid) chk("stb_during_rdata", 32'(stb), 32'h0);
    if (rdata_valid && rdata_ready) begin
      if (exp_rd.size() == 0) chk("unexpected_rdata", rdata, 32'hx);
      else begin
        r = exp_rd.pop_front();
        chk("rdata", rdata, r);
      end
    end
    pv_valid = rdata_valid;
    pv_ready = rdata_ready;
    pv_rdata = rdata;

    if (stb && !stb_prev) begin
      if (exp_bus.size() == 0) chk("unexpected_stb", adr_o, 32'hx);
      else begin
        b = exp_bus.pop_front();
        chk("bus_adr", adr_o, b.adr);
        chk("bus_we", 32'(we_o), 32'(b.we));
        chk("bus_sel", 32'(sel), 32'hF);
        chk("bus_cyc", 32'(cyc), 32'h1);
        if (b.we) chk("bus_dat", dat_o, b.dat);
      end
    end
    if (stb) run++;
    else begin
      if (stb_prev && chk_run) chk("stb_run_len", run, TO);
      run = 0;
    end
    stb_prev = stb;

    if (done) begin
      chk("done_pulse", 32'(done_prev), 32'h0);
      if (exp_err.size() == 0) chk("unexpected_done", 32'(err), 32'hx);
      else begin
        e = exp_err.pop_front();
        chk("err", 32'(err), 32'(e));
      end
      done_cnt++;
    end
    done_prev = done;
  end

  int ncmd = 0;

  task automatic issue(input bit wr, input logic [31:0] adr, input int len, input bit to, input bit seq);
    logic [31:0] a, ai, d;
    beat_t b;
    int k;
    a = adr & 32'hFFFF_FFFC;
    for (int i = 0; i < len; i++) begin
      if (to && i > 0) break;
      ai = a + 32'(4 * i);
      if (wr) begin
        d = seq ? 32'(i + 1) : $urandom;
        ref_mem[ai] = d;
        wq.push_back(d);
      end else begin
        d = ref_mem.exists(ai) ? ref_mem[ai] : 32'h0;
        if (!to) exp_rd.push_back(d);
      end
      b.we = wr; b.adr = ai; b.dat = d;
      exp_bus.push_back(b);
    end
    exp_err.push_back(to);
    k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) chk("cmd_ready_wait", 32'(cmd_ready), 32'h1);
    cmd_valid = 1'b1;
    cmd_we = wr;
    cmd_adr = adr;
    cmd_len = LEN_W'(len);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (done_cnt < target && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt < target) chk("done_wait", done_cnt, target);
    @(negedge clk);
  endtask

  task automatic run_cmd(input bit wr, input logic [31:0] adr, input int len, input bit to, input bit seq);
    issue(wr, adr, len, to, seq);
    ncmd++;
    wait_done(ncmd);
  endtask

  initial begin
    int k;
    rstn = 1'b0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_len = '0;
    wdata = '0; wdata_valid = 1'b0; rdata_ready = 1'b0;
    dat_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_cyc", 32'(cyc), 0);
    chk("rst_stb", 32'(stb), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rvalid", 32'(rdata_valid), 0);
    chk("rst_wready", 32'(wdata_ready), 0);
    chk("rst_sel", 32'(sel), 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 1);

    slv_delay = 10; rd_mode = 0;
    run_cmd(1'b1, 32'h3800_0000, 3, 1'b0, 1'b1);
    run_cmd(1'b0, 32'h3800_0000, 3, 1'b0, 1'b0);
    rd_mode = 2; slv_delay = 1;
    run_cmd(1'b0, 32'h3800_0000, 2, 1'b0, 1'b0);
    rd_mode = 0;

    slv_noack = 1'b1; chk_run = 1'b1;
    run_cmd(1'b0, 32'h3800_0040, 2, 1'b1, 1'b0);
    chk("err_held", 32'(err), 1);
    slv_noack = 1'b0; chk_run = 1'b0;

    slv_delay = 62;
    run_cmd(1'b0, 32'h3800_0004, 1, 1'b0, 1'b0);
    slv_delay = 63; chk_run = 1'b1;
    run_cmd(1'b0, 32'h3800_0004, 1, 1'b1, 1'b0);
    chk_run = 1'b0;

    issue(1'b0, 32'h3800_0100, 0, 1'b0, 1'b0);
    ncmd++;
    chk("len0_done_next", 32'(done), 1);
    chk("len0_no_cyc", 32'(cyc), 0);
    wait_done(ncmd);

    slv_delay = 1;
    run_cmd(1'b1, 32'hFFFF_FFFD, 2, 1'b0, 1'b0);
    rd_mode = 1;
    run_cmd(1'b0, 32'hFFFF_FFFC, 2, 1'b0, 1'b0);

    slv_delay = 20; rd_mode = 0;
    issue(1'b0, 32'h3800_0000, 4, 1'b0, 1'b0);
    k = 0;
    while (!stb && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("rst_test_stb_seen", 32'(stb), 1);
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_cyc", 32'(cyc), 0);
    chk("async_rst_stb", 32'(stb), 0);
    chk("async_rst_busy", 32'(busy), 0);
    exp_bus.delete(); exp_rd.delete(); exp_err.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", 32'(cmd_ready), 1);
    chk("no_done_on_reset", done_cnt, ncmd);
    slv_delay = 2; rd_mode = 1;
    run_cmd(1'b0, 32'h3800_0000, 4, 1'b0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      slv_delay = $urandom_range(0, 6);
      rd_mode = $urandom_range(0, 2);
      run_cmd(1'($urandom_range(1)), 32'h3800_0000 | ($urandom & 32'hFF),
              $urandom_range(0, 4), 1'b0, 1'b0);
    end

    chk("bus_left", exp_bus.size(), 0);
    chk("rd_left", exp_rd.size(), 0);
    chk("err_left", exp_err.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
